// File: rtl/b32p_bus_pkg.sv
// Shared definitions for the B32P data-memory bus responder: bus widths,
// the responder FSM state encoding and the value returned for missed reads.
package b32p_bus_pkg;

  localparam int unsigned BUS_ADDR_W = 27;
  localparam int unsigned BUS_DATA_W = 32;

  // Responder FSM states; encodings are fixed so waveforms stay comparable.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } bus_state_e;

  // Data returned by a read whose address falls outside the served window.
  localparam logic [BUS_DATA_W-1:0] BUS_RD_MISS = 32'h0000_0000;

endpackage

// File: rtl/b32p_bus_resp_ram.sv
// Single-port synchronous RAM used as the responder's local word storage.
// Read data is registered and only changes on a read access, so it holds the
// last word read until the next read.
module b32p_bus_resp_ram
  import b32p_bus_pkg::*;
#(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned IDX_W = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic                  re,
  input  logic [IDX_W-1:0]      idx,
  input  logic [BUS_DATA_W-1:0] wdata,
  output logic [BUS_DATA_W-1:0] rdata
);

  logic [BUS_DATA_W-1:0] mem [DEPTH];

  // Storage write and registered read; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[idx] <= wdata;
    end
    if (re) begin
      rdata <= mem[idx];
    end
  end

endmodule

// File: rtl/b32p_bus_responder.sv
// B32P data-memory bus responder: accepts a CPU transfer, waits WAIT_STATES
// cycles, then pulses bus_done for one cycle with read data on bus_q.
// Optional feature macro: B32P_BUS_RESP_ERR_EN adds the bus_err output,
// flagged alongside bus_done for transfers outside [BASE, BASE+DEPTH-1].
//
// Handshake: a request is accepted when bus_start is high at a rising edge
// while bus_busy is low (IDLE); address, data and we are captured at that
// edge. Starts seen while busy are dropped, not queued. Completion is the
// single-cycle bus_done pulse; bus_q is valid from that cycle until the next
// read completes.
module b32p_bus_responder
  import b32p_bus_pkg::*;
#(
  parameter int unsigned       ADDR_W      = BUS_ADDR_W,
  parameter int unsigned       DEPTH       = 1024,
  parameter logic [ADDR_W-1:0] BASE        = '0,
  parameter int unsigned       WAIT_STATES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  bus_start,
  input  logic [ADDR_W-1:0]     bus_addr,
  input  logic [BUS_DATA_W-1:0] bus_data,
  input  logic                  bus_we,
  output logic [BUS_DATA_W-1:0] bus_q,
  output logic                  bus_done,
  output logic                  bus_busy
`ifdef B32P_BUS_RESP_ERR_EN
  ,
  output logic                  bus_err
`endif
);

  localparam int unsigned       IDX_W   = $clog2(DEPTH);
  localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W+1)'(DEPTH);

  if (WAIT_STATES > 15) begin : g_ws_chk
    $error("WAIT_STATES must be in 0..15");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_chk
    $error("DEPTH must be a power of two and at least 2");
  end
  if (IDX_W > ADDR_W) begin : g_fit_chk
    $error("DEPTH must not exceed 2**ADDR_W");
  end

  bus_state_e            state;
  logic [3:0]            cnt;
  logic [ADDR_W-1:0]     addr_r;
  logic [BUS_DATA_W-1:0] data_r;
  logic                  we_r;
  logic                  q_hit;

  logic                  accept;
  logic                  commit;
  logic [ADDR_W-1:0]     c_addr;
  logic [BUS_DATA_W-1:0] c_data;
  logic                  c_we;
  logic [ADDR_W:0]       off;
  logic                  in_win;
  logic [IDX_W-1:0]      idx;
  logic [BUS_DATA_W-1:0] ram_rdata;

  // commit marks the edge that enters DONE; with zero wait states that is the
  // accept edge itself, so the live bus inputs are used instead of the latches.
  // Gating with reset keeps an aborted transfer from touching storage.
  assign accept = (state == IDLE) && bus_start;
  assign commit = reset && ((accept && (WAIT_STATES == 0)) ||
                            ((state == WAIT) && (cnt == 4'd1)));
  assign c_addr = (state == IDLE) ? bus_addr : addr_r;
  assign c_data = (state == IDLE) ? bus_data : data_r;
  assign c_we   = (state == IDLE) ? bus_we   : we_r;

  // Window check on an extended difference so BASE+DEPTH never overflows.
  assign off    = {1'b0, c_addr} - {1'b0, BASE};
  assign in_win = (c_addr >= BASE) && (off < DEPTH_X);
  assign idx    = in_win ? off[IDX_W-1:0] : '0;

  b32p_bus_resp_ram #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_ram (
    .clk   (clk),
    .we    (commit && c_we && in_win),
    .re    (commit && !c_we && in_win),
    .idx   (idx),
    .wdata (c_data),
    .rdata (ram_rdata)
  );

  // Transfer FSM: capture on accept, count wait states, one DONE cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      cnt    <= 4'd0;
      addr_r <= '0;
      data_r <= '0;
      we_r   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus_start) begin
            addr_r <= bus_addr;
            data_r <= bus_data;
            we_r   <= bus_we;
            if (WAIT_STATES == 0) begin
              state <= DONE;
            end else begin
              state <= WAIT;
              cnt   <= 4'(WAIT_STATES);
            end
          end
        end
        WAIT: begin
          if (cnt == 4'd1) begin
            state <= DONE;
            cnt   <= 4'd0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Read-source select: a completed read picks RAM data (hit) or the miss value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_hit <= 1'b0;
    end else if (commit && !c_we) begin
      q_hit <= in_win;
    end
  end

  assign bus_q    = q_hit ? ram_rdata : BUS_RD_MISS;
  assign bus_done = (state == DONE);
  assign bus_busy = (state != IDLE);

`ifdef B32P_BUS_RESP_ERR_EN
  logic miss_r;

  // Remember whether the transfer now completing was out of window.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      miss_r <= 1'b0;
    end else if (commit) begin
      miss_r <= !in_win;
    end
  end

  assign bus_err = bus_done && miss_r;
`endif

endmodule

// File: tb/tb_b32p_bus_responder.sv
// Bench for b32p_bus_responder: three instances (2 wait states / zero wait
// states / offset window of 16 words) driven by transfer tasks, with a
// reference memory model feeding an expected-data queue.
module tb_b32p_bus_responder;
  import b32p_bus_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        start [3];
  logic        we_i  [3];
  logic [26:0] addr  [3];
  logic [31:0] data  [3];
  logic [31:0] q     [3];
  logic        done  [3];
  logic        busy  [3];
`ifdef B32P_BUS_RESP_ERR_EN
  logic        err   [3];
`endif

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] exp_q[$];
  logic [31:0] mdl[longint];
  logic [31:0] last_q [3];

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  b32p_bus_responder #(.DEPTH(1024), .BASE(27'h0), .WAIT_STATES(2)) u_a (
    .clk(clk), .reset(rst_n), .bus_start(start[0]), .bus_addr(addr[0]),
    .bus_data(data[0]), .bus_we(we_i[0]), .bus_q(q[0]), .bus_done(done[0]),
    .bus_busy(busy[0])
`ifdef B32P_BUS_RESP_ERR_EN
    , .bus_err(err[0])
`endif
  );

  b32p_bus_responder #(.DEPTH(64), .BASE(27'h0), .WAIT_STATES(0)) u_b (
    .clk(clk), .reset(rst_n), .bus_start(start[1]), .bus_addr(addr[1]),
    .bus_data(data[1]), .bus_we(we_i[1]), .bus_q(q[1]), .bus_done(done[1]),
    .bus_busy(busy[1])
`ifdef B32P_BUS_RESP_ERR_EN
    , .bus_err(err[1])
`endif
  );

  b32p_bus_responder #(.DEPTH(16), .BASE(27'h100), .WAIT_STATES(1)) u_c (
    .clk(clk), .reset(rst_n), .bus_start(start[2]), .bus_addr(addr[2]),
    .bus_data(data[2]), .bus_we(we_i[2]), .bus_q(q[2]), .bus_done(done[2]),
    .bus_busy(busy[2])
`ifdef B32P_BUS_RESP_ERR_EN
    , .bus_err(err[2])
`endif
  );

  function automatic int ws_of(input int k);
    return (k == 0) ? 2 : (k == 1) ? 0 : 1;
  endfunction

  function automatic bit win_of(input int k, input logic [26:0] a);
    int unsigned base;
    int unsigned depth;
    base  = (k == 2) ? 32'h100 : 32'h0;
    depth = (k == 0) ? 1024 : (k == 1) ? 64 : 16;
    return (32'(a) >= base) && (32'(a) < base + depth);
  endfunction

  // driver: one full transfer on instance k, with scoreboard push / pop
  task automatic xfer(input int k, input logic we, input logic [26:0] a,
                      input logic [31:0] d, input bit scramble,
                      input logic [26:0] a2, input logic [31:0] d2);
    int          lat;
    bit          seen;
    bit          hit;
    longint      key;
    logic [31:0] exp;
    hit = win_of(k, a);
    key = (longint'(k) << 32) | longint'(a);
    if (we) begin
      if (hit) mdl[key] = d;
    end else begin
      last_q[k] = hit ? mdl[key] : 32'h0;
    end
    exp_q.push_back(last_q[k]);
    @(negedge clk);
    start[k] = 1'b1; we_i[k] = we; addr[k] = a; data[k] = d;
    @(posedge clk);
    lat = 0;
    seen = 1'b0;
    while (!seen && lat < 40) begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        start[k] = 1'b0;
        if (scramble) begin
          addr[k] = a2; data[k] = d2; we_i[k] = ~we;
        end
      end
      if (done[k]) seen = 1'b1;
    end
    exp = exp_q.pop_front();
    n_cmp++;
    if (!seen) begin
      n_bad++;
      $display("FAIL done_timeout k=%0d addr=%h: no done within %0d cycles", k, a, lat);
    end else begin
      n_cmp++;
      if (lat !== ws_of(k) + 1) begin
        n_bad++;
        $display("FAIL latency k=%0d addr=%h: got %0d cycles, want %0d", k, a, lat, ws_of(k) + 1);
      end
      if (q[k] !== exp) begin
        n_bad++;
        $display("FAIL q_at_done k=%0d addr=%h we=%0b: got %h, want %h", k, a, we, q[k], exp);
      end
`ifdef B32P_BUS_RESP_ERR_EN
      n_cmp++;
      if (err[k] !== !hit) begin
        n_bad++;
        $display("FAIL err_flag k=%0d addr=%h: got %b, want %b", k, a, err[k], !hit);
      end
`endif
      @(negedge clk);
      n_cmp++;
      if (done[k] !== 1'b0 || q[k] !== exp) begin
        n_bad++;
        $display("FAIL after_done k=%0d addr=%h: done=%b q=%h, want done=0 q=%h", k, a, done[k], q[k], exp);
      end
    end
    we_i[k] = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      last_q[k] = 32'h0;
      n_cmp++;
      if (q[k] !== 32'h0 || done[k] !== 1'b0 || busy[k] !== 1'b0) begin
        n_bad++;
        $display("FAIL reset_outputs k=%0d: q=%h done=%b busy=%b, want 0/0/0", k, q[k], done[k], busy[k]);
      end
    end
    n_cmp++;
    if (u_a.state !== IDLE || u_b.state !== IDLE || u_c.state !== IDLE) begin
      n_bad++;
      $display("FAIL reset_state: got %0d %0d %0d, want IDLE", u_a.state, u_b.state, u_c.state);
    end
  endtask

  task automatic test_write_read();
    xfer(0, 1'b1, 27'd5, 32'hDEADBEEF, 1'b0, '0, '0);
    xfer(0, 1'b0, 27'd5, 32'h0, 1'b0, '0, '0);
    xfer(0, 1'b1, 27'd6, 32'h600D600D, 1'b0, '0, '0);  // write keeps bus_q
    repeat (3) @(negedge clk);
    n_cmp++;
    if (q[0] !== 32'hDEADBEEF) begin
      n_bad++;
      $display("FAIL q_hold: got %h, want %h", q[0], 32'hDEADBEEF);
    end
  endtask

  task automatic test_zero_wait();
    int n;
    xfer(1, 1'b1, 27'd9, 32'h0BADF00D, 1'b0, '0, '0);
    xfer(1, 1'b0, 27'd9, 32'h0, 1'b0, '0, '0);
    @(negedge clk);
    start[1] = 1'b1; we_i[1] = 1'b0; addr[1] = 27'd9;
    repeat (4) exp_q.push_back(32'h0BADF00D);
    n = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (done[1]) begin
        n++;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL held_start_extra: unexpected done in cycle %0d", c);
        end else if (q[1] !== exp_q.pop_front()) begin
          n_bad++;
          $display("FAIL held_start_q: got %h, want %h", q[1], 32'h0BADF00D);
        end
      end
      if (c == 8) start[1] = 1'b0;
    end
    exp_q.delete();
    n_cmp++;
    if (n !== 4) begin
      n_bad++;
      $display("FAIL held_start_count: got %0d dones in 8 cycles, want 4", n);
    end
  endtask

  task automatic test_ignore_start();
    int n;
    int first;
    exp_q.push_back(mdl[longint'(5)]);
    @(negedge clk);
    start[0] = 1'b1; we_i[0] = 1'b0; addr[0] = 27'd5;
    @(posedge clk);
    n = 0;
    first = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 1) start[0] = 1'b0;
      if (c == 2) begin
        start[0] = 1'b1; we_i[0] = 1'b1; data[0] = 32'hFFFFFFFF;
      end
      if (c == 4) begin
        start[0] = 1'b0; we_i[0] = 1'b0;
      end
      if (done[0]) begin
        n++;
        if (n == 1) begin
          first = c;
          n_cmp++;
          if (q[0] !== exp_q.pop_front()) begin
            n_bad++;
            $display("FAIL ignore_q: got %h, want %h", q[0], 32'hDEADBEEF);
          end
        end
      end
    end
    n_cmp++;
    if (n !== 1 || first !== 3) begin
      n_bad++;
      $display("FAIL ignore_start: got %0d dones (first in cycle %0d), want 1 in cycle 3", n, first);
    end
    exp_q.delete();
    xfer(0, 1'b0, 27'd5, 32'h0, 1'b0, '0, '0);  // ignored write must not land
  endtask

  task automatic test_window();
    xfer(2, 1'b1, 27'h100, 32'h01010101, 1'b0, '0, '0);
    xfer(2, 1'b1, 27'h10F, 32'h0F0F0F0F, 1'b0, '0, '0);
    xfer(2, 1'b1, 27'h105, 32'h05050505, 1'b0, '0, '0);
    xfer(2, 1'b1, 27'h0FF, 32'h12345678, 1'b0, '0, '0);
    xfer(2, 1'b1, 27'h110, 32'h12345678, 1'b0, '0, '0);
    xfer(2, 1'b0, 27'h105, 32'h0, 1'b0, '0, '0);
    xfer(2, 1'b0, 27'h0FF, 32'h0, 1'b0, '0, '0);
    xfer(2, 1'b0, 27'h100, 32'h0, 1'b0, '0, '0);
    xfer(2, 1'b0, 27'h110, 32'h0, 1'b0, '0, '0);
    xfer(2, 1'b0, 27'h10F, 32'h0, 1'b0, '0, '0);
    xfer(2, 1'b0, 27'h4000105, 32'h0, 1'b0, '0, '0);
  endtask

  task automatic test_latch();
    xfer(0, 1'b1, 27'd7, 32'h77777777, 1'b0, '0, '0);
    xfer(0, 1'b1, 27'd3, 32'hA5A5A5A5, 1'b1, 27'd7, 32'h5A5A5A5A);
    xfer(0, 1'b0, 27'd3, 32'h0, 1'b0, '0, '0);
    xfer(0, 1'b0, 27'd7, 32'h0, 1'b0, '0, '0);
  endtask

  task automatic test_reset_abort();
    xfer(0, 1'b1, 27'h10, 32'h11112222, 1'b0, '0, '0);
    @(negedge clk);
    start[0] = 1'b1; we_i[0] = 1'b1; addr[0] = 27'h10; data[0] = 32'h33334444;
    @(posedge clk);
    @(negedge clk);
    start[0] = 1'b0;
    n_cmp++;
    if (busy[0] !== 1'b1) begin
      n_bad++;
      $display("FAIL busy_in_wait: got %b, want 1", busy[0]);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (busy[0] !== 1'b0 || done[0] !== 1'b0 || q[0] !== 32'h0) begin
      n_bad++;
      $display("FAIL async_reset: busy=%b done=%b q=%h, want 0/0/0", busy[0], done[0], q[0]);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    we_i[0] = 1'b0;
    for (int k = 0; k < 3; k++) last_q[k] = 32'h0;
    xfer(0, 1'b0, 27'h10, 32'h0, 1'b0, '0, '0);
  endtask

  task automatic test_random();
    logic [26:0] a;
    logic [31:0] d;
    for (int i = 0; i < 6; i++) begin
      a = 27'($urandom_range(32, 63));
      d = $urandom;
      xfer(1, 1'b1, a, d, 1'b0, '0, '0);
      xfer(1, 1'b0, a, 32'h0, 1'b0, '0, '0);
    end
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      start[k] = 1'b0; we_i[k] = 1'b0; addr[k] = '0; data[k] = '0; last_q[k] = '0;
    end
    rst_n = 1'b0;
    test_reset();
    test_write_read();
    test_zero_wait();
    test_ignore_start();
    test_window();
    test_latch();
    test_reset_abort();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // global watchdog so a stuck run still reports
  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
